pipelined_shifter: RTL

- Parametrised, pipelined shifter for the ALU shift/rotate path. Supersedes the fixed 8-bit combinational arithmetic-right shifter.
- Supports four modes: SLL, SRL, SRA and ROR.
- Supports any power-of-two width and saturating shift amounts.
- Uses one register per barrel stage with a valid/ready handshake and backpressure, so a tag (destination register id) travels with each operation.

---
 rtl/shifter_pkg.sv | 13 +
 rtl/shift_stage.sv | 51 +++++
 rtl/pipelined_shifter.sv | 53 +++++
 3 files changed

// File: rtl/shifter_pkg.sv
// shifter_pkg: mode encodings and width helper shared by the pipelined shifter
package shifter_pkg;
  localparam logic [1:0] MODE_SLL = 2'd0;
  localparam logic [1:0] MODE_SRL = 2'd1;
  localparam logic [1:0] MODE_SRA = 2'd2;
  localparam logic [1:0] MODE_ROR = 2'd3;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/shift_stage.sv
// shift_stage: one barrel level (shift by SHIFT when its amount bit is set) plus its pipeline register
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHIFT = 1,
  parameter int AW    = 3,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amount,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_sat,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [AW-1:0]    out_amount,
  output logic [1:0]       out_mode,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_sat
);
  localparam int B = clog2(SHIFT);
  logic [WIDTH-1:0] sh;
  // SRA stays correct across stages because the MSB always holds the original sign
  always_comb
    sh = !in_amount[B]         ? in_data
       : in_mode == MODE_SLL ? {in_data[WIDTH-SHIFT-1:0], {SHIFT{1'b0}}}
       : in_mode == MODE_SRL ? {{SHIFT{1'b0}}, in_data[WIDTH-1:SHIFT]}
       : in_mode == MODE_SRA ? {{SHIFT{in_data[WIDTH-1]}}, in_data[WIDTH-1:SHIFT]}
       :                       {in_data[SHIFT-1:0], in_data[WIDTH-1:SHIFT]};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_amount <= '0;
      out_mode   <= '0;
      out_tag    <= '0;
      out_sat    <= 1'b0;
    end else if (en) begin
      out_valid  <= in_valid;
      out_data   <= sh;
      out_amount <= in_amount;
      out_mode   <= in_mode;
      out_tag    <= in_tag;
      out_sat    <= in_sat;
    end
endmodule

// File: rtl/pipelined_shifter.sv
// pipelined_shifter: log2(WIDTH)-stage SLL/SRL/SRA/ROR shifter with valid/ready flow control and a tag sideband
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int TAG_W      = 3,
  parameter int SAT_AMOUNT = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [7:0]       in_amount,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  localparam int L = clog2(WIDTH);
  logic                        advance;
  logic [L:0]                  v, s;
  logic [L:0][WIDTH-1:0]       d;
  logic [L:0][L-1:0]           a;
  logic [L:0][1:0]             m;
  logic [L:0][TAG_W-1:0]       t;
  logic [L-1:0]                unused_amount;
  assign advance       = !out_valid || out_ready;
  assign in_ready      = advance;
  assign v[0]          = in_valid;
  assign d[0]          = in_data;
  assign a[0]          = L'(in_amount);
  assign m[0]          = in_mode;
  assign t[0]          = in_tag;
  assign s[0]          = SAT_AMOUNT != 0 && (in_amount >> L) != 8'd0 && in_mode != MODE_ROR;
  assign unused_amount = a[L];
  for (genvar k = 0; k < L; k++) begin : g_stage
    shift_stage #(.WIDTH(WIDTH), .SHIFT(1 << k), .AW(L), .TAG_W(TAG_W)) u_stage (
      .clk(CLK), .rst(RESET), .en(advance),
      .in_valid(v[k]), .in_data(d[k]), .in_amount(a[k]), .in_mode(m[k]), .in_tag(t[k]), .in_sat(s[k]),
      .out_valid(v[k+1]), .out_data(d[k+1]), .out_amount(a[k+1]), .out_mode(m[k+1]), .out_tag(t[k+1]),
      .out_sat(s[k+1])
    );
  end
  // oversized shifts collapse to zero, or to sign copies for SRA
  assign out_data  = !s[L] ? d[L] : m[L] == MODE_SRA ? {WIDTH{d[L][WIDTH-1]}} : '0;
  assign out_valid = v[L];
  assign out_tag   = t[L];
  assign busy      = |v[L:1];
endmodule
